// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the 256x32 memory arbiter:
//             sequencer state encoding, array geometry and requester IDs.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Default array geometry
  localparam int c_aw = 8;
  localparam int c_dw = 32;

  // Number of words addressed by an AW-bit address
  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

  localparam int c_depth = depth_of(c_aw);

  // Sequencer state encoding
  localparam logic c_st_run   = 1'b0;
  localparam logic c_st_clear = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN   = c_st_run,
    ST_CLEAR = c_st_clear
  } state_e;

  // Requester identifiers carried with each command
  localparam logic c_port0 = 1'b0;
  localparam logic c_port1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. A single pointer names the
//             favoured requester; it flips only when both requesters compete
//             and the arbiter is allowed to advance.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rstz,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // 0 = port 0 favoured, 1 = port 1 favoured
  logic ptr_q;
  logic ptr_d;

  // Grant decision and next pointer; nothing is granted while advance is low
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (adv_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          gnt_o = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Pointer register, favours port 0 out of reset
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arb_256x32.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_256x32
//  Purpose  : Two-port round-robin arbiter and sequencer for the 256x32
//             single-port data memory. Granted commands pass through a
//             one-stage command register; reads return two cycles after the
//             grant. A clear sweep writes zero to every word on request.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_256x32
  import mem_arb_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int DW = c_dw
) (
  input  logic          clk,
  input  logic          rstz,
  inout  wire           dvdd,
  inout  wire           dgnd,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  input  logic          clr,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // Last address of the clear sweep
  localparam logic [AW-1:0] c_cnt_last = AW'(depth_of(AW) - 1);

  // Supply pins carry no logic; tie them off so they do not float in lint
  wire w_unused_supply = ^{dvdd, dgnd};

  state_e        state_q;
  logic [AW-1:0] cnt_q;

  // Command register: valid, read flag, owner, plus the memory bus fields
  logic          cmd_vld_q;
  logic          cmd_rd_q;
  logic          cmd_own_q;
  logic          mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;

  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;

  logic          w_adv;
  logic [1:0]    w_gnt;
  logic          w_ret0;
  logic          w_ret1;

  // Arbitration only in RUN with no clear request; gnt is forced low in reset
  assign w_adv = rstz & (state_q == ST_RUN) & ~clr;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rstz  (rstz),
    .req_i ({req1, req0}),
    .adv_i (w_adv),
    .gnt_o (w_gnt)
  );

  assign gnt0 = w_gnt[0];
  assign gnt1 = w_gnt[1];

  // Sequencer: loads the command register from a grant or from the sweep
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_rd_q   <= 1'b0;
      cmd_own_q  <= c_port0;
      mem_rw_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      // Idle bus by default; address and data keep their last values
      cmd_vld_q <= 1'b0;
      cmd_rd_q  <= 1'b0;
      mem_rw_q  <= 1'b1;
      case (state_q)
        ST_RUN: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end else if (w_gnt[0]) begin
            cmd_vld_q  <= 1'b1;
            cmd_rd_q   <= rw0;
            cmd_own_q  <= c_port0;
            mem_rw_q   <= rw0;
            mem_addr_q <= addr0;
            mem_din_q  <= wdata0;
          end else if (w_gnt[1]) begin
            cmd_vld_q  <= 1'b1;
            cmd_rd_q   <= rw1;
            cmd_own_q  <= c_port1;
            mem_rw_q   <= rw1;
            mem_addr_q <= addr1;
            mem_din_q  <= wdata1;
          end
        end
        ST_CLEAR: begin
          // One zero write per cycle; the final one is on the bus in RUN
          cmd_vld_q  <= 1'b1;
          cmd_rd_q   <= 1'b0;
          mem_rw_q   <= 1'b0;
          mem_addr_q <= cnt_q;
          mem_din_q  <= '0;
          cnt_q      <= cnt_q + AW'(1);
          if (cnt_q == c_cnt_last) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // A read on the bus this cycle returns to the port that issued it
  assign w_ret0 = cmd_vld_q & cmd_rd_q & (cmd_own_q == c_port0);
  assign w_ret1 = cmd_vld_q & cmd_rd_q & (cmd_own_q == c_port1);

  // Per-port read data capture and one-cycle valid strobe
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= w_ret0;
      rvalid1_q <= w_ret1;
      if (w_ret0) begin
        rdata0_q <= mem_dout;
      end
      if (w_ret1) begin
        rdata1_q <= mem_dout;
      end
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign mem_en   = cmd_vld_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_256x32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb_256x32
//  Purpose  : Self-checking bench for mem_arb_256x32 with a behavioural
//             memory, a word-level reference array and a read-return queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb_256x32;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstz = 1'b0;
  wire           dvdd = 1'b1;
  wire           dgnd = 1'b0;
  logic          req0, rw0, req1, rw1, clr;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  bit fav = 1'b0;

  always #5 clk = ~clk;

  mem_arb_256x32 dut (
    .clk(clk), .rstz(rstz), .dvdd(dvdd), .dgnd(dgnd),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .clr(clr), .busy(busy),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Behavioural single-port memory
  logic [DW-1:0] mem [c_depth];
  always @(posedge clk) if (mem_en && !mem_rw) mem[mem_addr] <= mem_din;
  assign mem_dout = (mem_en && mem_rw) ? mem[mem_addr] : 32'hBAD0_BAD0;

  // Reference: word array updated at grant time, reads due two cycles later
  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
  rd_t exp_q[$];
  logic [DW-1:0] ref_mem [c_depth];
  int cyc = 0;

  always @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      exp_q.delete();
    end else begin
      if (gnt0) begin
        if (rw0) exp_q.push_back('{cyc + 2, 0, ref_mem[addr0]});
        else ref_mem[addr0] = wdata0;
      end
      if (gnt1) begin
        if (rw1) exp_q.push_back('{cyc + 2, 1, ref_mem[addr1]});
        else ref_mem[addr1] = wdata1;
      end
      cyc++;
    end
  end

  function automatic bit exp_rv(input int p, output logic [DW-1:0] d);
    exp_rv = 1'b0;
    d = '0;
    foreach (exp_q[i]) if (exp_q[i].due == cyc && exp_q[i].port == p) begin
      exp_rv = 1'b1;
      d = exp_q[i].data;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; rw0 = 1; rw1 = 1; clr = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rstz = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, busy} !== 6'b0) begin errors++;
      $display("FAIL rst_ctrl: got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, mem_en, busy}); end
    checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL rst_mem_rw: got %b want 1", mem_rw); end
    checks++; if (mem_addr !== 8'h00 || mem_din !== 32'h0) begin errors++;
      $display("FAIL rst_bus: addr %h din %h want 0", mem_addr, mem_din); end
    checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++;
      $display("FAIL rst_rdata: %h %h want 0", rdata0, rdata1); end
    rstz = 1;
    fav = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({mem_en, busy, gnt0, gnt1, rvalid0, rvalid1} !== 6'b0 || mem_rw !== 1'b1) begin errors++;
        $display("FAIL idle_%0d: en/busy/g0/g1/rv0/rv1 %b rw %b want 000000 1", i,
                 {mem_en, busy, gnt0, gnt1, rvalid0, rvalid1}, mem_rw); end
    end
  endtask

  task automatic test_write_read();
    req0 = 1; rw0 = 0; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt: g0 %b g1 %b want 1 0", gnt0, gnt1); end
    tick();
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 8'h10 || mem_din !== 32'hDEADBEEF) begin errors++;
      $display("FAIL wr_bus: en %b rw %b addr %h din %h want 1 0 10 deadbeef", mem_en, mem_rw, mem_addr, mem_din); end
    rw0 = 1;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", gnt0); end
    tick();
    req0 = 0;
    checks++; if (mem_en !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 8'h10 || rvalid0 !== 1'b0) begin errors++;
      $display("FAIL rd_bus: en %b rw %b addr %h rv0 %b want 1 1 10 0", mem_en, mem_rw, mem_addr, rvalid0); end
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin errors++;
      $display("FAIL rd_ret: rv0 %b rdata0 %h rv1 %b want 1 deadbeef 0", rvalid0, rdata0, rvalid1); end
    tick();
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF || mem_en !== 1'b0) begin errors++;
      $display("FAIL rd_hold: rv0 %b rdata0 %h en %b want 0 deadbeef 0", rvalid0, rdata0, mem_en); end
  endtask

  task automatic test_rr();
    int i0, i1;
    bit ev, av;
    logic [DW-1:0] ed, ad;
    logic [1:0] eg;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin req0 = 1; rw0 = 0; addr0 = 8'h40 + 8'(k); wdata0 = $urandom; req1 = 0; end
      else begin req0 = 0; req1 = 1; rw1 = 0; addr1 = 8'h80 + 8'(k - 4); wdata1 = $urandom; end
      tick();
    end
    req0 = 0; req1 = 0;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        req0 = 1; rw0 = 1; addr0 = 8'h40 + 8'(i0 & 3);
        req1 = 1; rw1 = 1; addr1 = 8'h80 + 8'(i1 & 3);
        #1;
        eg = fav ? 2'b10 : 2'b01;
        fav = ~fav;
        checks++; if ({gnt1, gnt0} !== eg) begin errors++; $display("FAIL rr_gnt_%0d: got %b want %b", c, {gnt1, gnt0}, eg); end
        if (gnt0) i0++;
        if (gnt1) i1++;
      end else begin
        req0 = 0; req1 = 0;
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        ev = exp_rv(p, ed);
        av = (p == 0) ? rvalid0 : rvalid1;
        ad = (p == 0) ? rdata0 : rdata1;
        checks++;
        if (av !== ev || (ev && ad !== ed)) begin errors++;
          $display("FAIL rr_ret_p%0d: rvalid %b rdata %h want rvalid %b rdata %h", p, av, ad, ev, ed); end
      end
    end
  endtask

  task automatic test_raw();
    logic [DW-1:0] d;
    d = $urandom;
    req1 = 1; rw1 = 0; addr1 = 8'h20; wdata1 = d;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL raw_wgnt: g1 %b g0 %b want 1 0", gnt1, gnt0); end
    tick();
    req1 = 0; req0 = 1; rw0 = 1; addr0 = 8'h20;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL raw_rgnt: got %b want 1", gnt0); end
    tick();
    req0 = 0;
    tick();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== d || rvalid1 !== 1'b0) begin errors++;
      $display("FAIL raw_data: rv0 %b rdata0 %h rv1 %b want 1 %h 0", rvalid0, rdata0, rvalid1, d); end
  endtask

  task automatic test_clear();
    int miss, nret;
    bit ok, ev;
    logic [DW-1:0] ed;
    miss = 0;
    req0 = 1; rw0 = 0; wdata0 = 32'hA5A5A5A5;
    for (int a = 0; a < c_depth; a++) begin
      addr0 = 8'(a);
      #1;
      if (gnt0 !== 1'b1) miss++;
      tick();
    end
    checks++; if (miss !== 0) begin errors++; $display("FAIL fill_gnt: %0d missed grants want 0", miss); end
    rw0 = 1; addr0 = 8'hFF; clr = 1;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL clr_cycle: g0 %b g1 %b busy %b want 0 0 0", gnt0, gnt1, busy); end
    for (int a = 0; a < c_depth; a++) ref_mem[a] = '0;
    tick();
    clr = 0;
    for (int i = 0; i < c_depth; i++) begin
      ok = (busy === 1'b1) && (gnt0 === 1'b0) && (gnt1 === 1'b0) && (rvalid0 === 1'b0) && (rvalid1 === 1'b0);
      if (i > 0) ok = ok && (mem_en === 1'b1) && (mem_rw === 1'b0) && (mem_addr === 8'(i - 1)) && (mem_din === 32'h0);
      else ok = ok && (mem_en === 1'b0);
      checks++;
      if (!ok) begin errors++;
        $display("FAIL clr_sweep_%0d: busy %b g0 %b en %b rw %b addr %h din %h", i, busy, gnt0, mem_en, mem_rw, mem_addr, mem_din); end
      clr = (i == 100);
      tick();
    end
    clr = 0;
    checks++; if (busy !== 1'b0 || mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 8'hFF) begin errors++;
      $display("FAIL clr_exit: busy %b en %b rw %b addr %h want 0 1 0 ff", busy, mem_en, mem_rw, mem_addr); end
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_resume: gnt0 %b want 1", gnt0); end
    nret = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ev = exp_rv(0, ed);
      checks++;
      if (rvalid0 !== ev || (ev && rdata0 !== 32'h0)) begin errors++;
        $display("FAIL clr_read_%0d: rvalid0 %b rdata0 %h want rvalid0 %b rdata0 0", k, rvalid0, rdata0, ev); end
      if (rvalid0 === 1'b1) nret++;
      if (k < 2) begin
        addr0 = (k == 0) ? 8'h00 : 8'h7F;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_rgnt_%0d: got %b want 1", k, gnt0); end
      end else begin
        req0 = 0;
      end
    end
    checks++; if (nret !== 3) begin errors++; $display("FAIL clr_nret: got %0d want 3", nret); end
  endtask

  task automatic test_random();
    bit pv [2];
    bit ev, av;
    logic [DW-1:0] ed, ad;
    logic [1:0] eg;
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 303; c++) begin
      if (c < 300) begin
        if (!pv[0] && $urandom_range(0, 9) < 6) begin
          pv[0] = 1; rw0 = 1'($urandom); addr0 = 8'($urandom_range(0, 15)); wdata0 = $urandom;
        end
        if (!pv[1] && $urandom_range(0, 9) < 6) begin
          pv[1] = 1; rw1 = 1'($urandom); addr1 = 8'($urandom_range(0, 15)); wdata1 = $urandom;
        end
      end
      req0 = pv[0]; req1 = pv[1];
      #1;
      if (pv[0] && pv[1]) begin eg = fav ? 2'b10 : 2'b01; fav = ~fav; end
      else eg = {pv[1], pv[0]};
      checks++; if ({gnt1, gnt0} !== eg) begin errors++; $display("FAIL rnd_gnt_%0d: got %b want %b", c, {gnt1, gnt0}, eg); end
      if (gnt0) pv[0] = 0;
      if (gnt1) pv[1] = 0;
      tick();
      for (int p = 0; p < 2; p++) begin
        ev = exp_rv(p, ed);
        av = (p == 0) ? rvalid0 : rvalid1;
        ad = (p == 0) ? rdata0 : rdata1;
        checks++;
        if (av !== ev || (ev && ad !== ed)) begin errors++;
          $display("FAIL rnd_ret_%0d_p%0d: rvalid %b rdata %h want rvalid %b rdata %h", c, p, av, ad, ev, ed); end
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d, ed, ad;
    bit ev, av;
    req1 = 1; rw1 = 1; addr1 = 8'h05;
    #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rm_gnt1: got %b want 1", gnt1); end
    tick();
    req1 = 0;
    #3; rstz = 0; #1;
    checks++; if ({mem_en, mem_rw, gnt0, gnt1, rvalid0, rvalid1, busy} !== 7'b0100000 || mem_addr !== 8'h00 || mem_din !== 32'h0) begin errors++;
      $display("FAIL rm_rd_reset: en/rw/g0/g1/rv0/rv1/busy %b addr %h din %h", {mem_en, mem_rw, gnt0, gnt1, rvalid0, rvalid1, busy}, mem_addr, mem_din); end
    fav = 0;
    @(posedge clk); #1; rstz = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin errors++;
        $display("FAIL rm_no_rv_%0d: rv0 %b rv1 %b rdata1 %h want 0 0 0", i, rvalid0, rvalid1, rdata1); end
    end
    d = $urandom;
    req0 = 1; rw0 = 0; addr0 = 8'hF0; wdata0 = d;
    tick();
    req0 = 0; clr = 1;
    tick();
    clr = 0;
    repeat (20) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", busy); end
    req0 = 1; rw0 = 1; addr0 = 8'hF0; req1 = 1; rw1 = 1; addr1 = 8'hF1;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL rm_clr_gnt: %b %b want 0 0", gnt0, gnt1); end
    #2; rstz = 0; #1;
    checks++; if ({busy, mem_en, gnt0, gnt1, rvalid0, rvalid1} !== 6'b0 || rdata0 !== 32'h0 || mem_rw !== 1'b1) begin errors++;
      $display("FAIL rm_clr_reset: busy/en/g0/g1/rv0/rv1 %b rdata0 %h rw %b", {busy, mem_en, gnt0, gnt1, rvalid0, rvalid1}, rdata0, mem_rw); end
    @(posedge clk); #1; rstz = 1; #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL rm_resume: got %b want 01", {gnt1, gnt0}); end
    fav = 1;
    tick();
    req0 = 0;
    #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rm_resume1: got %b want 1", gnt1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      req1 = 0;
      for (int p = 0; p < 2; p++) begin
        ev = exp_rv(p, ed);
        av = (p == 0) ? rvalid0 : rvalid1;
        ad = (p == 0) ? rdata0 : rdata1;
        checks++;
        if (av !== ev || (ev && ad !== ed)) begin errors++;
          $display("FAIL rm_ret_%0d_p%0d: rvalid %b rdata %h want rvalid %b rdata %h", i, p, av, ad, ev, ed); end
      end
    end
    checks++; if (rdata0 !== d || rdata1 !== 32'h0) begin errors++;
      $display("FAIL rm_final: rdata0 %h rdata1 %h want %h 0", rdata0, rdata1, d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rr();
    test_raw();
    test_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
